// File: rtl/a_fifo_writer.sv
// Write-side front end of the async pixel FIFO: 2-entry skid buffer feeding the
// FIFO write port, with frame counting against IMG_W*IMG_H and framing-error flag.
module a_fifo_writer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned CNT_W  = 17
) (
    input  logic              clk_100mhz,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              valid_in,
    input  logic              sof_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic              frame_done,
    output logic              frame_err,
    output logic [CNT_W-1:0]  pix_count
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] ONE_PIX   = CNT_W'(1);

    state_t              state_q, state_d;
    logic [1:0]          occ_q, occ_d;
    logic [DATA_W-1:0]   buf0_q, buf0_d;
    logic [DATA_W-1:0]   buf1_q, buf1_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic                write;
    logic                store;

    // Handshake outputs depend only on registers (plus fifo_full for the write side).
    assign ready_out  = (occ_q != 2'd2) && (state_q != DRAIN);
    assign fifo_wr_en = (occ_q != 2'd0) && !fifo_full;
    assign fifo_din   = buf0_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign pix_count  = cnt_q;

    assign accept = valid_in && ready_out;
    assign write  = fifo_wr_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        store   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && sof_in) begin
                    store   = 1'b1;
                    cnt_d   = ONE_PIX;
                    state_d = (FRAME_PIX == ONE_PIX) ? DRAIN : STREAM;
                end else if (accept) begin
                    err_d = 1'b1;
                end
            end
            STREAM: begin
                if (accept) begin
                    store = 1'b1;
                    if (sof_in) begin
                        err_d = 1'b1;
                        cnt_d = ONE_PIX;
                    end else begin
                        cnt_d = cnt_q + ONE_PIX;
                    end
                    if (cnt_d == FRAME_PIX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // No accepts in DRAIN, so a write at occupancy 1 empties the buffer.
                if (write && (occ_q == 2'd1)) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;

        case ({store, write})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = pixel_in;
                end else begin
                    buf1_d = pixel_in;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous pop and push: occupancy unchanged, new pixel goes to the tail.
                if (occ_q == 2'd1) begin
                    buf0_d = pixel_in;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = pixel_in;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            occ_q   <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_a_fifo_writer.sv
// Self-checking bench for a_fifo_writer (4x2 frames): scoreboard of stored pixels
// compared against every FIFO write, plus per-cycle handshake/framing checks.
module tb_a_fifo_writer;

    localparam int TOTAL = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  pixel_in;
    logic        valid_in;
    logic        sof_in;
    logic        ready_out;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        frame_done;
    logic        frame_err;
    logic [16:0] pix_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_q[$];
    int         m_cnt;
    bit         m_in_frame, m_drain, m_err, m_done;
    bit         rand_mode;
    int         n_writes, n_dones;

    always #5 clk = ~clk;

    a_fifo_writer #(
        .DATA_W(8),
        .IMG_W (4),
        .IMG_H (2),
        .CNT_W (17)
    ) dut (
        .clk_100mhz(clk),
        .reset_n   (reset_n),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .ready_out (ready_out),
        .fifo_din  (fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full (fifo_full),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .pix_count (pix_count)
    );

    task automatic clear_model();
        m_q.delete();
        m_cnt      = 0;
        m_in_frame = 0;
        m_drain    = 0;
        m_err      = 0;
        m_done     = 0;
        n_writes   = 0;
        n_dones    = 0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        valid_in  = 1'b0;
        sof_in    = 1'b0;
        fifo_full = 1'b0;
        pixel_in  = 8'h00;
        rand_mode = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_model();
    endtask

    // One clock: check outputs at negedge against the model, advance the model, return at posedge+1.
    task automatic step(output bit acc);
        bit         exp_ready, exp_wr, done_next;
        logic [7:0] head;
        @(negedge clk);
        exp_ready = (m_q.size() != 2) && !m_drain;
        exp_wr    = (m_q.size() != 0) && !fifo_full;
        n_cmp++;
        if (ready_out !== exp_ready) begin
            n_bad++;
            $display("FAIL ready_out: got %0b expected %0b at %0t", ready_out, exp_ready, $time);
        end
        n_cmp++;
        if (fifo_wr_en !== exp_wr) begin
            n_bad++;
            $display("FAIL fifo_wr_en: got %0b expected %0b at %0t", fifo_wr_en, exp_wr, $time);
        end
        n_cmp++;
        if (frame_done !== m_done) begin
            n_bad++;
            $display("FAIL frame_done: got %0b expected %0b at %0t", frame_done, m_done, $time);
        end
        n_cmp++;
        if (pix_count !== 17'(m_cnt)) begin
            n_bad++;
            $display("FAIL pix_count: got %0d expected %0d at %0t", pix_count, m_cnt, $time);
        end
        n_cmp++;
        if (frame_err !== m_err) begin
            n_bad++;
            $display("FAIL frame_err: got %0b expected %0b at %0t", frame_err, m_err, $time);
        end
        if (frame_done === 1'b1) n_dones++;
        done_next = 0;
        if (exp_wr) begin
            head = m_q.pop_front();
            n_writes++;
            n_cmp++;
            if (fifo_din !== head) begin
                n_bad++;
                $display("FAIL fifo_din: got %02h expected %02h at %0t", fifo_din, head, $time);
            end
            if (m_drain && m_q.size() == 0) begin
                done_next = 1;
                m_cnt     = 0;
                m_drain   = 0;
            end
        end
        acc = valid_in && exp_ready;
        if (acc) begin
            if (sof_in) begin
                if (m_in_frame) m_err = 1;
                m_q.push_back(pixel_in);
                m_cnt      = 1;
                m_in_frame = 1;
            end else if (!m_in_frame) begin
                m_err = 1;
            end else begin
                m_q.push_back(pixel_in);
                m_cnt++;
            end
            if (m_in_frame && m_cnt == TOTAL) begin
                m_in_frame = 0;
                m_drain    = 1;
            end
        end
        m_done = done_next;
        @(posedge clk);
        #1;
        if (rand_mode) fifo_full = ($urandom_range(0, 9) < 3);
    endtask

    task automatic send_pixel(input logic [7:0] data, input bit sof);
        bit acc = 0;
        pixel_in = data;
        sof_in   = sof;
        for (int i = 0; i < 200; i++) begin
            valid_in = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(acc);
            if (acc) break;
        end
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL send_timeout: pixel %02h accepted %0b required 1", data, acc);
        end
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    task automatic wait_idle();
        bit acc;
        bit idle = 0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_q.size() == 0 && !m_drain && !m_done) begin
                idle = 1;
                break;
            end
            step(acc);
        end
        n_cmp++;
        if (!idle) begin
            n_bad++;
            $display("FAIL drain_timeout: idle %0b required 1 (queued %0d)", idle, m_q.size());
        end
    endtask

    task automatic check_totals(input string name, input int writes, input int dones, input bit err);
        n_cmp++;
        if (n_writes != writes) begin
            n_bad++;
            $display("FAIL %s_writes: got %0d expected %0d", name, n_writes, writes);
        end
        n_cmp++;
        if (n_dones != dones) begin
            n_bad++;
            $display("FAIL %s_dones: got %0d expected %0d", name, n_dones, dones);
        end
        n_cmp++;
        if (frame_err !== err) begin
            n_bad++;
            $display("FAIL %s_err: got %0b expected %0b", name, frame_err, err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b expected 1", ready_out); end
        n_cmp++;
        if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %0b expected 0", fifo_wr_en); end
        n_cmp++;
        if (fifo_din !== 8'h00) begin n_bad++; $display("FAIL reset_din: got %02h expected 00", fifo_din); end
        n_cmp++;
        if (pix_count !== 17'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", pix_count); end
        n_cmp++;
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b expected 0", frame_done); end
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b expected 0", frame_err); end
    endtask

    task automatic test_single_frame();
        do_reset();
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h10 + i), i == 0);
        n_cmp++;
        if (pix_count !== 17'd8) begin n_bad++; $display("FAIL single_count8: got %0d expected 8", pix_count); end
        wait_idle();
        check_totals("single", 8, 1, 1'b0);
    endtask

    task automatic test_backpressure();
        bit acc;
        int idx, extra;
        do_reset();
        for (int i = 0; i < 3; i++) send_pixel(8'(8'h20 + i), i == 0);
        step(acc);
        fifo_full = 1'b1;
        idx   = 3;
        extra = 0;
        pixel_in = 8'(8'h20 + idx);
        valid_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(acc);
            if (acc) begin
                extra++;
                idx++;
                pixel_in = 8'(8'h20 + idx);
            end
        end
        n_cmp++;
        if (extra != 2) begin n_bad++; $display("FAIL bp_extra_accepts: got %0d expected 2", extra); end
        n_cmp++;
        if (ready_out !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %0b expected 0", ready_out); end
        valid_in  = 1'b0;
        fifo_full = 1'b0;
        while (idx < 8) begin
            send_pixel(8'(8'h20 + idx), 1'b0);
            idx++;
        end
        wait_idle();
        check_totals("bp", 8, 1, 1'b0);
    endtask

    task automatic test_leading();
        do_reset();
        send_pixel(8'hAA, 1'b0);
        send_pixel(8'hBB, 1'b0);
        n_cmp++;
        if (frame_err !== 1'b1) begin n_bad++; $display("FAIL lead_err_set: got %0b expected 1", frame_err); end
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h30 + i), i == 0);
        wait_idle();
        check_totals("lead", 8, 1, 1'b1);
    endtask

    task automatic test_premature_sof();
        do_reset();
        for (int i = 0; i < 4; i++) send_pixel(8'(8'h40 + i), i == 0);
        send_pixel(8'h50, 1'b1);
        n_cmp++;
        if (pix_count !== 17'd1) begin n_bad++; $display("FAIL presof_count: got %0d expected 1", pix_count); end
        n_cmp++;
        if (frame_err !== 1'b1) begin n_bad++; $display("FAIL presof_err: got %0b expected 1", frame_err); end
        for (int i = 1; i < 8; i++) send_pixel(8'(8'h50 + i), 1'b0);
        wait_idle();
        check_totals("presof", 12, 1, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        rand_mode = 1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) send_pixel(8'($urandom_range(0, 255)), i == 0);
        end
        rand_mode = 0;
        fifo_full = 1'b0;
        wait_idle();
        check_totals("random", 24, 3, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        fifo_full = 1'b1;
        send_pixel(8'h60, 1'b1);
        send_pixel(8'h61, 1'b0);
        fifo_full = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL mid_wr_en: got %0b expected 0", fifo_wr_en); end
        n_cmp++;
        if (fifo_din !== 8'h00) begin n_bad++; $display("FAIL mid_din: got %02h expected 00", fifo_din); end
        n_cmp++;
        if (pix_count !== 17'd0) begin n_bad++; $display("FAIL mid_count: got %0d expected 0", pix_count); end
        n_cmp++;
        if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_flags: got done=%0b err=%0b expected 0/0", frame_done, frame_err);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_model();
        n_cmp++;
        if (ready_out !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %0b expected 1", ready_out); end
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h70 + i), i == 0);
        wait_idle();
        check_totals("mid", 8, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_leading();
        test_premature_sof();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/a_fifo_writer.md
Name: a_fifo_writer

Overview:
Write-side front end of the async pixel FIFO, mirroring the reader that feeds the Sobel stage. It accepts a valid/ready pixel stream from the capture/source logic and buffers pixels in a 2-entry skid buffer. It writes them into the async FIFO write port under fifo_full backpressure. It also frames the stream by counting pixels against the image size and flags framing errors.

Parameters:
DATA_W, 8, pixel width in bits.
IMG_W, 256, pixels per line.
IMG_H, 256, lines per frame.
CNT_W, 17, width of the frame pixel counter; must hold IMG_W*IMG_H.

Ports:
clk_100mhz  in  1  write-domain clock (rising edge).
reset_n  in  1  asynchronous active-low reset.
pixel_in  in  DATA_W  source pixel.
valid_in  in  1  pixel_in valid.
sof_in  in  1  start-of-frame marker, qualified by valid_in; marks the first pixel of a frame.
ready_out  out  1  block can accept a pixel this cycle.
fifo_din  out  DATA_W  async FIFO write data.
fifo_wr_en  out  1  async FIFO write enable.
fifo_full  in  1  async FIFO full flag (write domain).
frame_done  out  1  one-cycle pulse: last pixel of a frame written into the FIFO.
frame_err  out  1  sticky framing-error flag; cleared only by reset.
pix_count  out  CNT_W  pixels accepted in the current frame.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, skid occupancy=0, pix_count=0, frame_done=0, frame_err=0, fifo_wr_en=0, fifo_din=0.
  - ready_out=1 after reset deasserts.
- Accept: a pixel is accepted when valid_in && ready_out.
- Skid buffer:
  - 2 entries, FIFO order; occupancy is a register with values 0..2.
  - ready_out = (occ != 2) && state != DRAIN, decoded from registers only. No combinational path from fifo_full to ready_out.
- Write:
  - fifo_wr_en = (occ != 0) && !fifo_full.
  - fifo_din = head entry.
  - Both are decoded from registers plus fifo_full only.
  - A write pops the head at the clock edge.
  - An accept and a write in the same cycle are legal; occupancy stays unchanged.
- Latency: a pixel accepted at edge N is presented on fifo_din at cycle N+1 at the earliest. Pixel order is preserved exactly.
- fifo_full held high: no writes, at most 2 further accepts, then ready_out drops. No pixel is lost or duplicated.
- States:
  - IDLE:
    - Accepted pixels without sof_in are discarded (not stored) and set frame_err.
    - An accepted pixel with sof_in is stored, pix_count=1, next state STREAM.
  - STREAM:
    - Each accept stores the pixel and increments pix_count.
    - The accept that makes pix_count == IMG_W*IMG_H moves to DRAIN.
    - An accepted pixel with sof_in set (premature SOF) sets frame_err, restarts pix_count at 1, and stays in STREAM. The stored pixel becomes the first pixel of the new frame; earlier pixels still drain.
  - DRAIN:
    - ready_out=0.
    - When the write that empties the buffer occurs, frame_done pulses for the following cycle, pix_count clears to 0, and the state returns to IDLE.
- pix_count holds its value during DRAIN until cleared.
- sof_in without valid_in is ignored.
- Special frame size: IMG_W*IMG_H == 1 is legal; the SOF pixel goes directly to DRAIN.
- Reset mid-frame: buffer contents are discarded immediately and no write is issued after reset assertion.

Test Plan:
- Single pixel: IMG_W=4, IMG_H=2, fifo_full=0, one pixel per cycle with sof_in on the first, values 0x10..0x17 -> fifo_wr_en high for 8 cycles starting 1 cycle after the first accept, fifo_din 0x10..0x17 in order, frame_done one pulse after the 0x17 write, pix_count=8 then 0, frame_err=0.
- Backpressure: fifo_full held high from pixel 3 for 10 cycles while valid_in stays high -> exactly 2 extra accepts, then ready_out=0. After release, the remaining pixels are written in order with no gaps lost and no duplicates; total writes = 8.
- Leading pixels: valid pixels 0xAA, 0xBB without sof_in, then a normal frame -> 0xAA and 0xBB are never written, frame_err=1, and the frame writes correctly.
- Premature SOF: sof_in on the 5th pixel of an 8-pixel frame -> frame_err=1, pix_count restarts at 1, the first 4 pixels plus the new frame's 8 are all written, and frame_done pulses once after the 12th write.
- Random stress: random valid_in and fifo_full over 3 frames -> scoreboard matches the written stream to the accepted stream exactly, frame_done count=3, and ready_out=0 throughout every DRAIN.
- Reset mid-frame: reset_n low for 2 cycles with occ=2 -> fifo_wr_en=0 immediately, all outputs at reset values, and the next frame is processed cleanly from IDLE.
